// File: rtl/button_pulse_gen_pkg.sv
// Shared definitions for the push-button front end: FSM state encoding and
// default timing constants for the board clock.
package button_pulse_gen_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      HELD         = 3'd2,
      REPEAT       = 3'd3,
      RELEASE_WAIT = 3'd4
   } state_t;

   localparam int DEF_CNT_W           = 16;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_REPEAT_EN       = 1;
   localparam int DEF_REPEAT_DELAY    = 50000;
   localparam int DEF_REPEAT_PERIOD   = 10000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input, with
// synchronous active-high reset clearing both stages.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // NOTE: non-blocking assignments let each flop capture the pre-edge value; blocking would collapse the chain into one stage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/button_pulse_gen.sv
// Debounces a raw push-button and emits one-cycle press/repeat strobes and a
// release strobe, all from registered outputs.
module button_pulse_gen
   import button_pulse_gen_pkg::*;
#(
   parameter int CNT_W           = DEF_CNT_W,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = DEF_REPEAT_EN,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clock,
   input  logic reset,
   input  logic button_in,
   output logic button_pulse,
   output logic button_level,
   output logic release_pulse
);

   // The timer counts stable samples already seen, so the current sample closes
   // the debounce window at DEBOUNCE_CYCLES-1 (pulse after edge E+1+DEBOUNCE_CYCLES).
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] TMR_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TMR_MAX   = '1;
   localparam bit               DEB_SHORT = (DEBOUNCE_CYCLES == 1);
   localparam bit               RPT_ON    = (REPEAT_EN != 0);

   logic             sync_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             rel_q,   rel_d;

   sync_2ff u_sync (
      .clk_i (clock),
      .rst_i (reset),
      .d_i   (button_in),
      .q_o   (sync_q)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            level_d = 1'b0;
            if (sync_q) begin
               if (DEB_SHORT) begin
                  state_d = HELD;
                  press_d = 1'b1;
                  level_d = 1'b1;
               end else begin
                  state_d = PRESS_WAIT;
                  timer_d = TMR_ONE;
               end
            end
         end

         PRESS_WAIT: begin
            if (!sync_q) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (timer_q == DEB_LAST) begin
               state_d = HELD;
               press_d = 1'b1;
               level_d = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_ONE;
            end
         end

         HELD, REPEAT: begin
            if (!sync_q) begin
               if (DEB_SHORT) begin
                  state_d = IDLE;
                  level_d = 1'b0;
                  rel_d   = 1'b1;
                  timer_d = '0;
               end else begin
                  state_d = RELEASE_WAIT;
                  timer_d = TMR_ONE;
               end
            end else if (state_q == HELD) begin
               if (RPT_ON && (timer_q == DLY_LAST)) begin
                  state_d = REPEAT;
                  press_d = 1'b1;
                  timer_d = '0;
               end else if (timer_q != TMR_MAX) begin
                  timer_d = timer_q + TMR_ONE;
               end
            end else if (timer_q == PER_LAST) begin
               press_d = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_ONE;
            end
         end

         RELEASE_WAIT: begin
            if (sync_q) begin
               // Bounce during release: back to HELD, repeat delay restarts.
               state_d = HELD;
               timer_d = '0;
            end else if (timer_q == DEB_LAST) begin
               state_d = IDLE;
               level_d = 1'b0;
               rel_d   = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_ONE;
            end
         end

         default: begin
            state_d = IDLE;
            timer_d = '0;
            level_d = 1'b0;
         end
      endcase
   end

   assign button_pulse  = press_q;
   assign button_level  = level_q;
   assign release_pulse = rel_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Scoreboard bench for button_pulse_gen: directed button waveforms push the
// expected strobe (kind, edge number) and a negedge monitor pops and compares.
module tb_button_pulse_gen;

   typedef enum int {EV_NONE = 0, EV_PRESS = 1, EV_RELEASE = 2} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       cyc;
   } ev_t;

   logic clock = 1'b0;
   logic reset;
   logic button_in;
   logic button_pulse, button_level, release_pulse;
   logic norep_pulse, norep_level, norep_release;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   ev_t  sb_q[$];
   logic [3:0] counter4 = 4'd0;
   int   norep_pulse_cnt = 0;
   int   norep_rel_cnt   = 0;

   button_pulse_gen #(
      .CNT_W(16), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .button_in     (button_in),
      .button_pulse  (button_pulse),
      .button_level  (button_level),
      .release_pulse (release_pulse)
   );

   button_pulse_gen #(
      .CNT_W(16), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
   ) dut_norep (
      .clock         (clock),
      .reset         (reset),
      .button_in     (button_in),
      .button_pulse  (norep_pulse),
      .button_level  (norep_level),
      .release_pulse (norep_release)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic expect_ev(input ev_kind_t k, input int c);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      sb_q.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   // Monitor: every strobe from the main DUT must match the head of the scoreboard.
   always @(negedge clock) begin
      ev_t      exp_ev;
      ev_kind_t kind;
      if (button_pulse === 1'b1 || release_pulse === 1'b1) begin
         check("pulse_exclusive", int'(button_pulse & release_pulse), 0);
         kind = (button_pulse === 1'b1) ? EV_PRESS : EV_RELEASE;
         if (sb_q.size() == 0) begin
            exp_ev.kind = EV_NONE;
            exp_ev.cyc  = 0;
         end else begin
            exp_ev = sb_q.pop_front();
         end
         check("strobe_kind", int'(kind), int'(exp_ev.kind));
         check("strobe_edge", cyc, exp_ev.cyc);
      end
      if (button_pulse === 1'b1) counter4 = counter4 + 4'd1;
      if (norep_pulse === 1'b1) norep_pulse_cnt++;
      if (norep_release === 1'b1) norep_rel_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int np0, nr0;
      logic [3:0] c0, cdiff;

      button_in = 1'b0;
      reset     = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_pulse", int'(button_pulse), 0);
      check("reset_level", int'(button_level), 0);
      check("reset_release", int'(release_pulse), 0);
      reset = 1'b0;
      repeat (5) @(negedge clock);

      // Clean press: held 10 cycles.
      base = cyc + 1;
      expect_ev(EV_PRESS, base + 5);
      expect_ev(EV_RELEASE, base + 15);
      button_in = 1'b1;
      wait_until(base + 4);  check("clean_level_before", int'(button_level), 0);
      wait_until(base + 5);  check("clean_level_set", int'(button_level), 1);
      wait_until(base + 9);  button_in = 1'b0;
      wait_until(base + 14); check("clean_level_hold", int'(button_level), 1);
      wait_until(base + 15); check("clean_level_clear", int'(button_level), 0);
      wait_until(base + 20);

      // Bounce: 1,0,1,0,1,0 then steady high.
      base = cyc + 1;
      expect_ev(EV_PRESS, base + 11);
      expect_ev(EV_RELEASE, base + 21);
      for (int i = 0; i < 6; i++) begin
         button_in = (i % 2 == 0);
         @(negedge clock);
      end
      button_in = 1'b1;
      wait_until(base + 10); check("bounce_level_before", int'(button_level), 0);
      wait_until(base + 11); check("bounce_level_set", int'(button_level), 1);
      wait_until(base + 15); button_in = 1'b0;
      wait_until(base + 26);

      // Auto-repeat: held 60 cycles.
      base = cyc + 1;
      np0  = norep_pulse_cnt;
      nr0  = norep_rel_cnt;
      expect_ev(EV_PRESS, base + 5);
      expect_ev(EV_PRESS, base + 25);
      expect_ev(EV_PRESS, base + 33);
      expect_ev(EV_PRESS, base + 41);
      expect_ev(EV_PRESS, base + 49);
      expect_ev(EV_PRESS, base + 57);
      expect_ev(EV_RELEASE, base + 65);
      button_in = 1'b1;
      wait_until(base + 30);
      check("repeat_level", int'(button_level), 1);
      check("norep_level", int'(norep_level), 1);
      wait_until(base + 59); button_in = 1'b0;
      wait_until(base + 70);
      check("norep_pulse_count", norep_pulse_cnt - np0, 1);
      check("norep_release_count", norep_rel_cnt - nr0, 1);

      // Release glitch: low for 2 cycles while held.
      base = cyc + 1;
      expect_ev(EV_PRESS, base + 5);
      expect_ev(EV_RELEASE, base + 29);
      button_in = 1'b1;
      wait_until(base + 9);  button_in = 1'b0;
      wait_until(base + 11); button_in = 1'b1;
      wait_until(base + 13); check("glitch_level_mid", int'(button_level), 1);
      wait_until(base + 16); check("glitch_level_after", int'(button_level), 1);
      wait_until(base + 23); button_in = 1'b0;
      wait_until(base + 28); check("glitch_level_hold", int'(button_level), 1);
      wait_until(base + 29); check("glitch_level_clear", int'(button_level), 0);
      wait_until(base + 34);

      // Reset mid-hold at edge 30.
      base = cyc + 1;
      expect_ev(EV_PRESS, base + 5);
      expect_ev(EV_PRESS, base + 25);
      expect_ev(EV_PRESS, base + 36);
      expect_ev(EV_RELEASE, base + 45);
      button_in = 1'b1;
      wait_until(base + 29); reset = 1'b1;
      wait_until(base + 30); reset = 1'b0;
      check("midreset_pulse", int'(button_pulse), 0);
      check("midreset_level", int'(button_level), 0);
      check("midreset_release", int'(release_pulse), 0);
      wait_until(base + 35); check("midreset_level_before", int'(button_level), 0);
      wait_until(base + 36); check("midreset_level_set", int'(button_level), 1);
      wait_until(base + 39); button_in = 1'b0;
      wait_until(base + 50);

      // Counter integration: 17 clean presses into a 4-bit counter.
      c0 = counter4;
      for (int p = 0; p < 17; p++) begin
         base = cyc + 1;
         expect_ev(EV_PRESS, base + 5);
         expect_ev(EV_RELEASE, base + 13);
         button_in = 1'b1;
         wait_until(base + 7);  button_in = 1'b0;
         wait_until(base + 19);
      end
      cdiff = counter4 - c0;
      check("counter_wrap", int'(cdiff), 1);

      check("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
